// File: rtl/wb_commit_unit.sv
// Writeback commit unit: holds the GPR file and HI/LO, commits the WB slot,
// serves write-first bypassed reads to decode, drives the debug trace and retire counters.
module wb_commit_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stall,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_writereg,
  input  logic [31:0]      wb_result,
  input  logic             wb_hilo_write,
  input  logic [63:0]      wb_hilo,
  input  logic             wb_cp0_write,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic [31:0]      rd1,
  output logic [31:0]      rd2,
  output logic [31:0]      hi_out,
  output logic [31:0]      lo_out,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_wen,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [15:0]      cp0_write_cnt
);

  localparam int unsigned NREGS  = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CP0_W  = 16;

  logic [DATA_W-1:0] gpr_q [NREGS];
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic [CP0_W-1:0]  cp0_cnt_q, cp0_cnt_d;

  logic commit_c;
  logic reg_commit_c;
  logic gpr_we_c;
  logic hilo_we_c;

  // A held or empty slot never touches state, counters or bypass paths.
  assign commit_c     = resetn & wb_valid & ~stall;
  assign reg_commit_c = commit_c & wb_regwrite;
  assign gpr_we_c     = reg_commit_c & (wb_writereg != 5'd0);
  assign hilo_we_c    = commit_c & wb_hilo_write;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    cp0_cnt_d    = cp0_cnt_q;
    if (commit_c) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
      if (wb_cp0_write) cp0_cnt_d = cp0_cnt_q + CP0_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) gpr_q[i] <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      retire_cnt_q <= '0;
      cp0_cnt_q    <= '0;
    end else begin
      if (gpr_we_c) gpr_q[wb_writereg] <= wb_result;
      if (hilo_we_c) begin
        hi_q <= wb_hilo[63:32];
        lo_q <= wb_hilo[31:0];
      end
      retire_cnt_q <= retire_cnt_d;
      cp0_cnt_q    <= cp0_cnt_d;
    end
  end

  // Write-first read ports; r0 is hardwired to zero.
  always_comb begin
    rd1 = gpr_q[ra1];
    rd2 = gpr_q[ra2];
    if (reg_commit_c && (wb_writereg == ra1)) rd1 = wb_result;
    if (reg_commit_c && (wb_writereg == ra2)) rd2 = wb_result;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

  assign hi_out = hilo_we_c ? wb_hilo[63:32] : hi_q;
  assign lo_out = hilo_we_c ? wb_hilo[31:0]  : lo_q;

  // wen stays high for an r0 write so the golden trace lines up.
  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_wen   = {4{reg_commit_c}};
  assign debug_wb_rf_wnum  = wb_writereg;
  assign debug_wb_rf_wdata = wb_result;

  assign retire_cnt    = retire_cnt_q;
  assign cp0_write_cnt = cp0_cnt_q;

  // An empty WB slot carries the reset PC and never requests a GPR write.
  a_empty_slot : assert property (@(posedge clk) disable iff (!resetn)
    !wb_valid |-> (!wb_regwrite && (wb_pc == RESET_PC)));

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: reference model plus a queue of
// expected counter values pushed at each clock edge and popped after it.
module tb_wb_commit_unit;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        resetn, stall, wb_valid, wb_regwrite, wb_hilo_write, wb_cp0_write;
  logic [31:0] wb_pc, wb_result;
  logic [4:0]  wb_writereg, ra1, ra2;
  logic [63:0] wb_hilo;
  logic [31:0] rd1, rd2, hi_out, lo_out, debug_wb_pc, debug_wb_rf_wdata, retire_cnt;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [15:0] cp0_write_cnt;

  logic [31:0] w_rd1, w_rd2, w_hi, w_lo, w_pc, w_wdata;
  logic [3:0]  w_wen, w_retire_cnt;
  logic [4:0]  w_wnum;
  logic [15:0] w_cp0;

  always #5 clk = ~clk;

  wb_commit_unit #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_result(wb_result),
    .wb_hilo_write(wb_hilo_write), .wb_hilo(wb_hilo), .wb_cp0_write(wb_cp0_write),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .hi_out(hi_out), .lo_out(lo_out),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retire_cnt(retire_cnt), .cp0_write_cnt(cp0_write_cnt)
  );

  // Narrow-counter instance so the retire counter wrap is reachable quickly.
  wb_commit_unit #(.RESET_PC(RESET_PC), .CNT_W(4)) dut_w (
    .clk(clk), .resetn(resetn), .stall(stall), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_result(wb_result),
    .wb_hilo_write(wb_hilo_write), .wb_hilo(wb_hilo), .wb_cp0_write(wb_cp0_write),
    .ra1(ra1), .ra2(ra2), .rd1(w_rd1), .rd2(w_rd2), .hi_out(w_hi), .lo_out(w_lo),
    .debug_wb_pc(w_pc), .debug_wb_rf_wen(w_wen),
    .debug_wb_rf_wnum(w_wnum), .debug_wb_rf_wdata(w_wdata),
    .retire_cnt(w_retire_cnt), .cp0_write_cnt(w_cp0)
  );

  typedef struct {
    logic [31:0] ret;
    logic [15:0] cp0;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo, m_ret;
  logic [15:0] m_cp0;
  int          checks = 0;
  int          passed = 0;

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (resetn && wb_valid && !stall && wb_regwrite && (wb_writereg == a)) return wb_result;
    return m_gpr[a];
  endfunction

  task automatic idle();
    wb_valid = 1'b0; stall = 1'b0; wb_pc = RESET_PC; wb_regwrite = 1'b0;
    wb_writereg = 5'd0; wb_result = 32'd0; wb_hilo_write = 1'b0; wb_hilo = 64'd0;
    wb_cp0_write = 1'b0;
  endtask

  task automatic drive(input logic [4:0] wr, input logic [31:0] res, input logic rw);
    wb_valid = 1'b1; wb_pc = 32'h8000_0000 + {27'd0, wr} * 4; wb_regwrite = rw;
    wb_writereg = wr; wb_result = res;
  endtask

  // Advance the model through one edge, queue the expected counters, then clock the DUT.
  task automatic tick();
    exp_t x;
    if (!resetn) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_hi = 32'd0; m_lo = 32'd0; m_ret = 32'd0; m_cp0 = 16'd0;
    end else if (wb_valid && !stall) begin
      if (wb_regwrite && wb_writereg != 5'd0) m_gpr[wb_writereg] = wb_result;
      if (wb_hilo_write) begin m_hi = wb_hilo[63:32]; m_lo = wb_hilo[31:0]; end
      m_ret = m_ret + 32'd1;
      if (wb_cp0_write) m_cp0 = m_cp0 + 16'd1;
    end
    x.ret = m_ret; x.cp0 = m_cp0;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; idle(); ra1 = 5'd0; ra2 = 5'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++; if (retire_cnt !== e.ret) $display("FAIL reset_retire got %h exp %h", retire_cnt, e.ret); else passed++;
    end
    resetn = 1'b1;
    tick();
    e = exp_q.pop_front();
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a); #1;
      checks++; if (rd1 !== 32'd0) $display("FAIL reset_rd1[%0d] got %h exp 0", a, rd1); else passed++;
      checks++; if (rd2 !== 32'd0) $display("FAIL reset_rd2[%0d] got %h exp 0", 31 - a, rd2); else passed++;
    end
    checks++; if ({hi_out, lo_out} !== 64'd0) $display("FAIL reset_hilo got %h exp 0", {hi_out, lo_out}); else passed++;
    checks++; if (retire_cnt !== 32'd0) $display("FAIL reset_cnt got %h exp 0", retire_cnt); else passed++;
    checks++; if (cp0_write_cnt !== 16'd0) $display("FAIL reset_cp0 got %h exp 0", cp0_write_cnt); else passed++;
    checks++; if (debug_wb_rf_wen !== 4'h0) $display("FAIL reset_wen got %h exp 0", debug_wb_rf_wen); else passed++;
  endtask

  task automatic test_bypass();
    drive(5'd5, 32'hdeadbeef, 1'b1); ra1 = 5'd5; ra2 = 5'd5; #1;
    checks++; if (rd1 !== 32'hdeadbeef) $display("FAIL bypass_rd1 got %h exp deadbeef", rd1); else passed++;
    checks++; if (rd2 !== 32'hdeadbeef) $display("FAIL bypass_rd2 got %h exp deadbeef", rd2); else passed++;
    checks++; if (debug_wb_rf_wen !== 4'hf) $display("FAIL bypass_wen got %h exp f", debug_wb_rf_wen); else passed++;
    checks++; if (debug_wb_rf_wnum !== 5'd5 || debug_wb_rf_wdata !== 32'hdeadbeef)
      $display("FAIL bypass_trace got %0d/%h exp 5/deadbeef", debug_wb_rf_wnum, debug_wb_rf_wdata); else passed++;
    tick();
    e = exp_q.pop_front();
    idle(); ra2 = 5'd6; #1;
    checks++; if (rd1 !== 32'hdeadbeef) $display("FAIL array_rd1 got %h exp deadbeef", rd1); else passed++;
    checks++; if (rd2 !== 32'd0) $display("FAIL array_rd2_other got %h exp 0", rd2); else passed++;
    checks++; if (retire_cnt !== e.ret || e.ret !== 32'd1) $display("FAIL bypass_cnt got %h exp 1", retire_cnt); else passed++;
  endtask

  task automatic test_r0_write();
    drive(5'd0, 32'h12345678, 1'b1); ra1 = 5'd0; #1;
    checks++; if (debug_wb_rf_wen !== 4'hf) $display("FAIL r0_wen got %h exp f", debug_wb_rf_wen); else passed++;
    checks++; if (rd1 !== 32'd0) $display("FAIL r0_bypass got %h exp 0", rd1); else passed++;
    tick();
    e = exp_q.pop_front();
    idle(); #1;
    checks++; if (rd1 !== 32'd0) $display("FAIL r0_read got %h exp 0", rd1); else passed++;
    checks++; if (retire_cnt !== e.ret) $display("FAIL r0_cnt got %h exp %h", retire_cnt, e.ret); else passed++;
  endtask

  task automatic test_stall();
    logic [31:0] r7_before, ret_before, hi_before, lo_before;
    r7_before = m_gpr[7]; ret_before = m_ret; hi_before = m_hi; lo_before = m_lo;
    drive(5'd7, 32'h7777_0007, 1'b1); stall = 1'b1;
    wb_hilo_write = 1'b1; wb_hilo = 64'h0000000a_0000000b; ra1 = 5'd7;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rd1 !== r7_before) $display("FAIL stall_rd1 c%0d got %h exp %h", c, rd1, r7_before); else passed++;
      checks++; if (hi_out !== hi_before || lo_out !== lo_before)
        $display("FAIL stall_hilo c%0d got %h_%h exp %h_%h", c, hi_out, lo_out, hi_before, lo_before); else passed++;
      checks++; if (debug_wb_rf_wen !== 4'h0) $display("FAIL stall_wen c%0d got %h exp 0", c, debug_wb_rf_wen); else passed++;
      tick();
      e = exp_q.pop_front();
      checks++; if (retire_cnt !== e.ret || e.ret !== ret_before)
        $display("FAIL stall_cnt c%0d got %h exp %h", c, retire_cnt, ret_before); else passed++;
    end
    stall = 1'b0; #1;
    checks++; if (rd1 !== 32'h7777_0007) $display("FAIL release_bypass got %h exp 77770007", rd1); else passed++;
    checks++; if (hi_out !== 32'ha || lo_out !== 32'hb) $display("FAIL release_hilo_bypass got %h_%h exp a_b", hi_out, lo_out); else passed++;
    tick();
    e = exp_q.pop_front();
    idle(); #1;
    checks++; if (rd1 !== 32'h7777_0007) $display("FAIL release_r7 got %h exp 77770007", rd1); else passed++;
    checks++; if (hi_out !== 32'ha || lo_out !== 32'hb) $display("FAIL release_hilo got %h_%h exp a_b", hi_out, lo_out); else passed++;
    checks++; if (retire_cnt !== e.ret || e.ret !== ret_before + 32'd1)
      $display("FAIL release_cnt got %h exp %h", retire_cnt, ret_before + 32'd1); else passed++;
    tick();
    e = exp_q.pop_front();
    checks++; if (retire_cnt !== e.ret) $display("FAIL release_once got %h exp %h", retire_cnt, e.ret); else passed++;
  endtask

  task automatic test_flush();
    idle(); wb_cp0_write = 1'b1; wb_writereg = 5'd3; wb_result = 32'hbad0_0003; ra1 = 5'd3; #1;
    checks++; if (debug_wb_pc !== RESET_PC) $display("FAIL flush_pc got %h exp %h", debug_wb_pc, RESET_PC); else passed++;
    checks++; if (debug_wb_rf_wen !== 4'h0) $display("FAIL flush_wen got %h exp 0", debug_wb_rf_wen); else passed++;
    tick();
    e = exp_q.pop_front();
    #1;
    checks++; if (rd1 !== m_gpr[3]) $display("FAIL flush_gpr got %h exp %h", rd1, m_gpr[3]); else passed++;
    checks++; if (retire_cnt !== e.ret) $display("FAIL flush_cnt got %h exp %h", retire_cnt, e.ret); else passed++;
    checks++; if (cp0_write_cnt !== e.cp0 || e.cp0 !== 16'd0) $display("FAIL flush_cp0 got %h exp 0", cp0_write_cnt); else passed++;
  endtask

  task automatic test_cp0();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 32'd0, 1'b0); wb_cp0_write = 1'b1;
      tick();
      e = exp_q.pop_front();
      checks++; if (cp0_write_cnt !== e.cp0 || e.cp0 !== 16'(i + 1))
        $display("FAIL cp0_cnt i%0d got %h exp %h", i, cp0_write_cnt, 16'(i + 1)); else passed++;
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) idle();
      else begin
        drive(5'($urandom_range(0, 31)), $urandom(), 1'($urandom_range(0, 1)));
        wb_hilo_write = 1'($urandom_range(0, 1)); wb_hilo = {$urandom(), $urandom()};
      end
      wb_cp0_write = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 3) == 0);
      ra1 = ($urandom_range(0, 1) == 1) ? wb_writereg : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 1) == 1) ? wb_writereg : 5'($urandom_range(0, 31));
      #1;
      checks++; if (rd1 !== exp_rd(ra1)) $display("FAIL b2b_rd1 n%0d got %h exp %h", n, rd1, exp_rd(ra1)); else passed++;
      checks++; if (rd2 !== exp_rd(ra2)) $display("FAIL b2b_rd2 n%0d got %h exp %h", n, rd2, exp_rd(ra2)); else passed++;
      checks++; if (hi_out !== ((wb_valid && !stall && wb_hilo_write) ? wb_hilo[63:32] : m_hi) ||
                    lo_out !== ((wb_valid && !stall && wb_hilo_write) ? wb_hilo[31:0] : m_lo))
        $display("FAIL b2b_hilo n%0d got %h_%h", n, hi_out, lo_out); else passed++;
      tick();
      e = exp_q.pop_front();
      checks++; if (retire_cnt !== e.ret || cp0_write_cnt !== e.cp0)
        $display("FAIL b2b_cnt n%0d got %h/%h exp %h/%h", n, retire_cnt, cp0_write_cnt, e.ret, e.cp0); else passed++;
    end
    idle();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16 && m_ret[3:0] != 4'hf; i++) begin
      drive(5'd0, 32'd0, 1'b0);
      tick();
      e = exp_q.pop_front();
      checks++; if (retire_cnt !== e.ret) $display("FAIL wrap_wide i%0d got %h exp %h", i, retire_cnt, e.ret); else passed++;
    end
    idle(); #1;
    checks++; if (w_retire_cnt !== 4'hf) $display("FAIL wrap_pre got %h exp f", w_retire_cnt); else passed++;
    drive(5'd0, 32'd0, 1'b0);
    tick();
    e = exp_q.pop_front();
    idle(); #1;
    checks++; if (w_retire_cnt !== 4'h0) $display("FAIL wrap_post got %h exp 0", w_retire_cnt); else passed++;
    checks++; if (retire_cnt !== e.ret) $display("FAIL wrap_wide_post got %h exp %h", retire_cnt, e.ret); else passed++;
  endtask

  task automatic test_reset_collision();
    drive(5'd9, 32'h9999_0009, 1'b1); wb_hilo_write = 1'b1; wb_hilo = 64'h1111_2222_3333_4444;
    wb_cp0_write = 1'b1; ra1 = 5'd9; ra2 = 5'd5; resetn = 1'b0; #1;
    checks++; if (debug_wb_rf_wen !== 4'h0) $display("FAIL rstcol_wen got %h exp 0", debug_wb_rf_wen); else passed++;
    checks++; if (rd1 !== m_gpr[9]) $display("FAIL rstcol_nobypass got %h exp %h", rd1, m_gpr[9]); else passed++;
    tick();
    e = exp_q.pop_front();
    resetn = 1'b1; idle(); #1;
    checks++; if (rd1 !== 32'd0 || rd2 !== 32'd0) $display("FAIL rstcol_gpr got %h/%h exp 0/0", rd1, rd2); else passed++;
    checks++; if ({hi_out, lo_out} !== 64'd0) $display("FAIL rstcol_hilo got %h exp 0", {hi_out, lo_out}); else passed++;
    checks++; if (retire_cnt !== 32'd0 || cp0_write_cnt !== 16'd0 || e.ret !== 32'd0)
      $display("FAIL rstcol_cnt got %h/%h exp 0/0", retire_cnt, cp0_write_cnt); else passed++;
    drive(5'd4, 32'h0000_0044, 1'b1); ra1 = 5'd4;
    tick();
    e = exp_q.pop_front();
    idle(); #1;
    checks++; if (rd1 !== 32'h44) $display("FAIL post_reset_commit got %h exp 44", rd1); else passed++;
    checks++; if (retire_cnt !== e.ret || e.ret !== 32'd1) $display("FAIL post_reset_cnt got %h exp 1", retire_cnt); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'hx;
    m_hi = 32'hx; m_lo = 32'hx; m_ret = 32'hx; m_cp0 = 16'hx;
    test_reset();
    test_bypass();
    test_r0_write();
    test_stall();
    test_flush();
    test_cp0();
    test_back_to_back();
    test_wrap();
    test_reset_collision();
    checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Architectural-state end of the writeback interface. Consumes the registered WB-stage outputs and commits them into the GPR file and the HI/LO pair.
- Provides bypassed read ports to the decode stage.
- Drives the SoC debug trace and keeps a retired-instruction counter.
- Sits after the WB pipeline register, alongside decode.

Parameters:
- RESET_PC, 32'hbfc00000, PC value that marks an empty/flushed WB slot; used only by tests as a reference value.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- stall  in  1  WB stage held; suppresses commit
- wb_valid  in  1  WB slot holds a real instruction; 0 after flush or reset
- wb_pc  in  32  PC of the WB instruction
- wb_regwrite  in  1  GPR write request
- wb_writereg  in  5  GPR destination
- wb_result  in  32  GPR write data
- wb_hilo_write  in  1  HI/LO write request
- wb_hilo  in  64  {HI,LO} write data
- wb_cp0_write  in  1  CP0 write marker; counted only, no state here
- ra1, ra2  in  5  decode read addresses
- rd1, rd2  out  32  decode read data, bypassed
- hi_out, lo_out  out  32  HI/LO read data, bypassed
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_wen  out  4  trace byte write enables
- debug_wb_rf_wnum  out  5  trace destination
- debug_wb_rf_wdata  out  32  trace data
- retire_cnt  out  CNT_W  committed-instruction count
- cp0_write_cnt  out  16  committed CP0 writes

Behaviour:
- Reset and clock: resetn is synchronous, active-low; clock is clk. While resetn=0, at every posedge:
  - all 32 GPRs clear to 0;
  - HI and LO clear to 0;
  - retire_cnt and cp0_write_cnt clear to 0.
  - Reset overrides any simultaneous commit.
- commit = resetn & wb_valid & ~stall.
- GPR write: at posedge, if commit & wb_regwrite & (wb_writereg != 0), then GPR[wb_writereg] <= wb_result.
- r0: reads always return 0; a write to r0 is discarded.
- HI/LO write: at posedge, if commit & wb_hilo_write, then HI <= wb_hilo[63:32] and LO <= wb_hilo[31:0]. Both halves are always written together.
- Read ports, combinational, zero latency:
  - rd1 = 0 if ra1 == 0;
  - else wb_result if commit & wb_regwrite & (wb_writereg == ra1);
  - else GPR[ra1].
  - rd2 follows the same rule with ra2.
  - Both ports may bypass the same write simultaneously.
- hi_out/lo_out: wb_hilo halves if commit & wb_hilo_write, else the stored HI/LO.
- Retire counter: retire_cnt += 1 on each commit. Wraps modulo 2^CNT_W with no saturation.
- CP0 counter: cp0_write_cnt += 1 on commit & wb_cp0_write. Wraps at 16 bits.
- Stall: while stall=1 there are no state updates, no count, and no bypass. The instruction commits exactly once, on the first cycle with stall=0.
- Flush: arrives as wb_valid=0 with wb_regwrite=0. Nothing is committed or counted.
- Trace outputs, combinational from current inputs:
  - debug_wb_pc = wb_pc;
  - debug_wb_rf_wen = {4{commit & wb_regwrite}}. This stays asserted for a write to r0, so the golden trace still matches; the data is dropped internally.
  - debug_wb_rf_wnum = wb_writereg;
  - debug_wb_rf_wdata = wb_result.
  - During reset, debug_wb_rf_wen = 0.
- Simultaneous events:
  - GPR write and HI/LO write in one commit are independent; both occur.
  - A read of a register being written returns the new data in the same cycle (write-first).
  - An unstalled commit on the first cycle after resetn rises is legal.

Test Plan:
- Reset for 2 cycles, then release with wb_valid=0 → rd1/rd2 = 0 for all addresses, hi_out = lo_out = 0, retire_cnt = 0, debug_wb_rf_wen = 4'h0.
- Commit wb_writereg=5, wb_result=32'hdeadbeef, ra1=5 in the same cycle → rd1 = deadbeef combinationally (bypass). Next cycle with regwrite=0 → rd1 = deadbeef from the array; retire_cnt = 1.
- Commit wb_writereg=0, wb_result=32'h12345678 → debug_wb_rf_wen = 4'hf this cycle; afterwards ra1=0 → rd1 = 0.
- Hold stall=1 for 3 cycles with wb_regwrite=1, wb_writereg=7, wb_hilo_write=1, wb_hilo=64'h0000000a_0000000b:
  - during the stall: rd on r7 is unchanged, hi/lo unchanged, debug_wb_rf_wen = 0, retire_cnt frozen;
  - on release: r7 is written, HI = 0000000a, LO = 0000000b, retire_cnt += 1 exactly once.
- Flush slot (wb_valid=0, wb_pc=32'hbfc00000, wb_regwrite=0, wb_cp0_write=1) → no GPR change, retire_cnt and cp0_write_cnt unchanged.
- Preload retire_cnt to 32'hffffffff via 2^32-1 forced commits (or a force), then commit once more → wraps to 0. Asserting resetn=0 in the same cycle as a commit → all state is 0 after that edge.
